// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_arb_pkg : owner encoding and load/store funct3 codes            |
// | Revision    : 1.0                                                   |
// +--------------------------------------------------------------------+
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  localparam logic [2:0] LF3_LB  = 3'b000;
  localparam logic [2:0] LF3_LH  = 3'b001;
  localparam logic [2:0] LF3_LW  = 3'b010;
  localparam logic [2:0] LF3_LBU = 3'b100;
  localparam logic [2:0] LF3_LHU = 3'b101;

  localparam logic [2:0] SF3_SB  = 3'b000;
  localparam logic [2:0] SF3_SH  = 3'b001;
  localparam logic [2:0] SF3_SW  = 3'b010;

  // True when the access must be rejected: unknown funct3 or bad alignment.
  function automatic logic dm_reject(input logic we, input logic [2:0] f3,
                                     input logic [1:0] a);
    logic bad;
    bad = 1'b1;
    if (we) begin
      case (f3)
        SF3_SB:  bad = 1'b0;
        SF3_SH:  bad = a[0];
        SF3_SW:  bad = |a;
        default: bad = 1'b1;
      endcase
    end else begin
      case (f3)
        LF3_LB, LF3_LBU: bad = 1'b0;
        LF3_LH, LF3_LHU: bad = a[0];
        LF3_LW:          bad = |a;
        default:         bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | load_extend : align a memory word to a load and sign/zero extend it |
// | Revision    : 1.0                                                   |
// +--------------------------------------------------------------------+
module load_extend
  import mem_arb_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  a_r,
  input  logic [2:0]  f3_r,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {a_r, 3'b000};
    case (f3_r)
      LF3_LB:  rdata = {{24{shifted[7]}}, shifted[7:0]};
      LF3_LH:  rdata = {{16{shifted[15]}}, shifted[15:0]};
      LF3_LW:  rdata = shifted;
      LF3_LBU: rdata = {24'd0, shifted[7:0]};
      LF3_LHU: rdata = {16'd0, shifted[15:0]};
      default: rdata = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_port_arbiter : fetch/data arbiter for one single-ported memory  |
// | Revision         : 1.0                                              |
// +--------------------------------------------------------------------+
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [2:0]  dm_f3,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        dm_stall,
  output logic        dm_misalign,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

  owner_t      owner_q, owner_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [1:0]  a_q, a_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;

  logic        dm_bad;
  logic        dm_ok;
  logic        dm_gnt;
  logic        if_gnt;
  logic [1:0]  dm_a;
  logic [31:0] load_data;
  logic        unused_if_lsb;

  assign dm_a          = dm_addr[1:0];
  assign unused_if_lsb = ^if_addr[1:0];

  // Grant: data normally wins; a starved fetch takes one slot. Nothing is
  // granted while reset is held.
  always_comb begin
    dm_bad = dm_req && dm_reject(dm_we, dm_f3, dm_a);
    dm_ok  = dm_req && !dm_bad;
    dm_gnt = rst_n && dm_ok && !(if_req && (starve_cnt_q == STARVE_LIMIT));
    if_gnt = rst_n && if_req && !dm_gnt;
  end

  always_comb begin
    if_stall    = rst_n && if_req && !if_gnt;
    dm_stall    = rst_n && dm_ok && !dm_gnt;
    dm_misalign = rst_n && dm_bad;
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_be    = 4'd0;
    if (dm_gnt) begin
      mem_en   = 1'b1;
      mem_we   = dm_we;
      mem_addr = {dm_addr[31:2], 2'b00};
      if (dm_we) begin
        mem_wdata = dm_wdata << {dm_a, 3'b000};
        case (dm_f3)
          SF3_SB:  mem_be = 4'b0001 << dm_a;
          SF3_SH:  mem_be = 4'b0011 << dm_a;
          default: mem_be = 4'b1111;
        endcase
      end
    end else if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = {if_addr[31:2], 2'b00};
    end
  end

  always_comb begin
    owner_d      = OWN_NONE;
    starve_cnt_d = starve_cnt_q;
    a_d          = a_q;
    f3_d         = f3_q;
    we_d         = we_q;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (dm_gnt) begin
      owner_d = OWN_DM;
    end
    if (dm_gnt) begin
      a_d  = dm_a;
      f3_d = dm_f3;
      we_d = dm_we;
    end
    if (!if_req || if_gnt) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q != STARVE_LIMIT) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q      <= OWN_NONE;
      starve_cnt_q <= 4'd0;
      a_q          <= 2'd0;
      f3_q         <= 3'd0;
      we_q         <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      a_q          <= a_d;
      f3_q         <= f3_d;
      we_q         <= we_d;
    end
  end

  load_extend u_load_extend (
    .word  (mem_rdata),
    .a_r   (a_q),
    .f3_r  (f3_q),
    .rdata (load_data)
  );

  // Responses are masked during reset so an in-flight access is dropped.
  always_comb begin
    if_valid = rst_n && (owner_q == OWN_IF);
    dm_valid = rst_n && (owner_q == OWN_DM);
    if_rdata = if_valid ? mem_rdata : 32'd0;
    dm_rdata = (dm_valid && !we_q) ? load_data : 32'd0;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_port_arbiter : directed bench with response scoreboard       |
// | Revision            : 1.0                                           |
// +--------------------------------------------------------------------+
module tb_mem_port_arbiter;

  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid, if_stall;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [2:0]  dm_f3;
  logic [31:0] dm_rdata;
  logic        dm_valid, dm_stall, dm_misalign;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] rd_word;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        iv;
    logic        dv;
    logic [31:0] id;
    logic [31:0] dd;
  } resp_t;

  resp_t sb[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_f3(dm_f3), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .dm_stall(dm_stall), .dm_misalign(dm_misalign),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(rd_word)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    if_req = 1'b0; if_addr = 32'd0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0; dm_f3 = 3'd0;
  endtask

  task automatic chk_port(input string tag, input logic en, input logic we,
                          input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata);
    chk({tag, ".mem_en"},    32'(mem_en),    32'(en));
    chk({tag, ".mem_we"},    32'(mem_we),    32'(we));
    chk({tag, ".mem_addr"},  mem_addr,       addr);
    chk({tag, ".mem_be"},    32'(mem_be),    32'(be));
    chk({tag, ".mem_wdata"}, mem_wdata,      wdata);
  endtask

  task automatic chk_flags(input string tag, input logic ist, input logic dst,
                           input logic mis);
    chk({tag, ".if_stall"},    32'(if_stall),    32'(ist));
    chk({tag, ".dm_stall"},    32'(dm_stall),    32'(dst));
    chk({tag, ".dm_misalign"}, 32'(dm_misalign), 32'(mis));
  endtask

  // Push the response this cycle's grant must produce, advance one clock,
  // then pop and compare against the response outputs.
  task automatic tick(input string tag, input logic iv, input logic dv,
                      input logic [31:0] id, input logic [31:0] dd);
    resp_t e;
    e.iv = iv; e.dv = dv; e.id = id; e.dd = dd;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({tag, ".if_valid"}, 32'(if_valid), 32'(e.iv));
    chk({tag, ".dm_valid"}, 32'(dm_valid), 32'(e.dv));
    chk({tag, ".if_rdata"}, if_rdata, e.id);
    chk({tag, ".dm_rdata"}, dm_rdata, e.dd);
  endtask

  // Both requesters held: data wins SM cycles, then fetch gets one slot.
  task automatic contend(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      logic fetch_turn;
      fetch_turn = ((i % (SM + 1)) == SM);
      if_req = 1'b1; if_addr = 32'h100;
      dm_req = 1'b1; dm_we = 1'b0; dm_f3 = 3'b010; dm_addr = 32'h200;
      #1;
      chk_flags($sformatf("%s%0d", tag, i), !fetch_turn, fetch_turn, 1'b0);
      chk($sformatf("%s%0d.mem_addr", tag, i), mem_addr,
          fetch_turn ? 32'h100 : 32'h200);
      if (fetch_turn) tick($sformatf("%s%0d", tag, i), 1'b1, 1'b0, rd_word, 32'd0);
      else            tick($sformatf("%s%0d", tag, i), 1'b0, 1'b1, 32'd0, rd_word);
    end
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] exp;
  } ld_t;

  initial begin
    ld_t loads[6];
    loads[0] = '{3'b000, 32'h3, 32'hFFFF_FF80};
    loads[1] = '{3'b100, 32'h3, 32'h0000_0080};
    loads[2] = '{3'b001, 32'h2, 32'hFFFF_80FF};
    loads[3] = '{3'b101, 32'h2, 32'h0000_80FF};
    loads[4] = '{3'b010, 32'h0, 32'h80FF_7F01};
    loads[5] = '{3'b000, 32'h1, 32'h0000_007F};

    // Reset with both requesters active: every output held at zero.
    rd_word = 32'h0;
    rst_n = 1'b0;
    idle();
    if_req = 1'b1; dm_req = 1'b1; dm_f3 = 3'b010;
    repeat (2) @(posedge clk);
    #1;
    chk_port("rst", 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    chk_flags("rst", 1'b0, 1'b0, 1'b0);
    chk("rst.if_valid", 32'(if_valid), 32'd0);
    chk("rst.dm_valid", 32'(dm_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();
    #1;
    chk("post_rst.if_valid", 32'(if_valid), 32'd0);
    chk("post_rst.dm_valid", 32'(dm_valid), 32'd0);
    chk("post_rst.mem_en",   32'(mem_en),   32'd0);
    tick("post_rst", 1'b0, 1'b0, 32'd0, 32'd0);

    // Fetch only.
    rd_word = 32'h0000_0013;
    for (int i = 0; i < 3; i++) begin
      if_req = 1'b1; if_addr = 32'(i * 4);
      #1;
      chk_port($sformatf("fetch%0d", i), 1'b1, 1'b0, 32'(i * 4), 4'd0, 32'd0);
      chk_flags($sformatf("fetch%0d", i), 1'b0, 1'b0, 1'b0);
      tick($sformatf("fetch%0d", i), 1'b1, 1'b0, rd_word, 32'd0);
    end
    idle();
    tick("fetch_end", 1'b0, 1'b0, 32'd0, 32'd0);

    // Contention: D,D,D,D,I repeating.
    rd_word = 32'h1122_3344;
    contend("cont", 10);
    idle();
    tick("cont_end", 1'b0, 1'b0, 32'd0, 32'd0);

    // Store lane steering.
    dm_req = 1'b1; dm_we = 1'b1; dm_f3 = 3'b000; dm_addr = 32'h13; dm_wdata = 32'hAB;
    #1;
    chk_port("sb", 1'b1, 1'b1, 32'h10, 4'b1000, 32'hAB00_0000);
    tick("sb", 1'b0, 1'b1, 32'd0, 32'd0);
    dm_f3 = 3'b001; dm_addr = 32'h12; dm_wdata = 32'h1234;
    #1;
    chk_port("sh", 1'b1, 1'b1, 32'h10, 4'b1100, 32'h1234_0000);
    tick("sh", 1'b0, 1'b1, 32'd0, 32'd0);
    dm_f3 = 3'b010; dm_addr = 32'h8; dm_wdata = 32'hDEAD_BEEF;
    #1;
    chk_port("sw", 1'b1, 1'b1, 32'h8, 4'b1111, 32'hDEAD_BEEF);
    tick("sw", 1'b0, 1'b1, 32'd0, 32'd0);

    // Load alignment and extension.
    rd_word = 32'h80FF_7F01;
    dm_we = 1'b0; dm_wdata = 32'd0;
    for (int i = 0; i < 6; i++) begin
      dm_req = 1'b1; dm_f3 = loads[i].f3; dm_addr = 32'h40 | loads[i].addr;
      #1;
      chk_port($sformatf("ld%0d", i), 1'b1, 1'b0, 32'h40, 4'd0, 32'd0);
      tick($sformatf("ld%0d", i), 1'b0, 1'b1, 32'd0, loads[i].exp);
    end
    idle();
    tick("ld_end", 1'b0, 1'b0, 32'd0, 32'd0);

    // Misaligned LW alongside a fetch: fetch proceeds, pulse fires.
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_we = 1'b0; dm_f3 = 3'b010; dm_addr = 32'h6;
    #1;
    chk_flags("mis_lw", 1'b0, 1'b0, 1'b1);
    chk_port("mis_lw", 1'b1, 1'b0, 32'h40, 4'd0, 32'd0);
    tick("mis_lw", 1'b1, 1'b0, rd_word, 32'd0);
    idle();
    #1;
    chk("mis_lw.pulse_end", 32'(dm_misalign), 32'd0);
    tick("mis_lw_end", 1'b0, 1'b0, 32'd0, 32'd0);

    // Unknown load funct3 and misaligned SH, no fetch.
    dm_req = 1'b1; dm_we = 1'b0; dm_f3 = 3'b011; dm_addr = 32'h0;
    #1;
    chk_flags("bad_f3", 1'b0, 1'b0, 1'b1);
    chk("bad_f3.mem_en", 32'(mem_en), 32'd0);
    tick("bad_f3", 1'b0, 1'b0, 32'd0, 32'd0);
    dm_we = 1'b1; dm_f3 = 3'b001; dm_addr = 32'h11; dm_wdata = 32'h5555;
    #1;
    chk_flags("mis_sh", 1'b0, 1'b0, 1'b1);
    chk("mis_sh.mem_en", 32'(mem_en), 32'd0);
    tick("mis_sh", 1'b0, 1'b0, 32'd0, 32'd0);
    idle();
    tick("mis_end", 1'b0, 1'b0, 32'd0, 32'd0);

    // Build up starvation, grant a load, then reset in the response cycle.
    rd_word = 32'hCAFE_F00D;
    contend("pre", 3);
    if_req = 1'b1; if_addr = 32'h100;
    dm_req = 1'b1; dm_we = 1'b0; dm_f3 = 3'b010; dm_addr = 32'h200;
    #1;
    chk("mid.mem_addr", mem_addr, 32'h200);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst.dm_valid", 32'(dm_valid), 32'd0);
    chk("mid_rst.dm_rdata", dm_rdata, 32'd0);
    chk("mid_rst.mem_en",   32'(mem_en),   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rel.if_valid", 32'(if_valid), 32'd0);
    chk("rel.dm_valid", 32'(dm_valid), 32'd0);
    // Counter restarted from zero: four data grants before fetch again.
    contend("rel", 5);
    idle();
    tick("rel_end", 1'b0, 1'b0, 32'd0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
